// File: rtl/vc_credit_tx_port.sv
// Credit-based upstream transmitter: round-robin picks one VC per cycle among those with a
// pending flit and a free downstream slot, and registers that flit onto the buffer write port.
module vc_credit_tx_port #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUF_BITS     = 1,
    parameter int Q_DEPTH_BITS = 3
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [(1<<BUF_BITS)-1:0]                        src_valid,
    input  logic [(1<<BUF_BITS)*DATA_WIDTH-1:0]             src_data,
    output logic [(1<<BUF_BITS)-1:0]                        src_ready,
    input  logic                                            credit_in,
    input  logic [BUF_BITS-1:0]                             credit_vc,
    output logic                                            wrtEn,
    output logic [DATA_WIDTH-1:0]                           write_data,
    output logic [BUF_BITS-1:0]                             in_vc,
    output logic [(1<<BUF_BITS)*(Q_DEPTH_BITS+1)-1:0]       credits,
    output logic                                            credit_err,
    output logic                                            dbg_state
);
    localparam int NUM_VC = 1 << BUF_BITS;
    localparam int CW     = Q_DEPTH_BITS + 1;
    localparam int CW1    = CW + 1;
    localparam int CMAX   = 1 << Q_DEPTH_BITS;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    // Handshake: src_ready[v] is a one-hot pop strobe in the grant cycle; the source must
    // treat (src_valid[v] && src_ready[v]) at a rising edge as the flit being consumed.

    state_t                  state_q, state_d;
    logic [CW-1:0]           credit_q [NUM_VC];
    logic [CW-1:0]           credit_d [NUM_VC];
    logic [BUF_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic [BUF_BITS-1:0]     in_vc_q, in_vc_d;
    logic                    err_q, err_d;

    logic [NUM_VC-1:0]       eligible;
    logic                    any_elig;
    logic [BUF_BITS-1:0]     gnt_vc;
    logic [NUM_VC-1:0]       gnt_oh;

    // Eligibility only sees the registered count, so a credit returning to an empty VC
    // becomes usable one cycle later.
    always_comb begin
        eligible = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            eligible[v] = src_valid[v] && (credit_q[v] != '0);
        end
    end

    always_comb begin
        logic [BUF_BITS-1:0] idx;
        any_elig = 1'b0;
        gnt_vc   = '0;
        idx      = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = rr_ptr_q + BUF_BITS'(i);
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                gnt_vc   = idx;
            end
        end
        gnt_oh = any_elig ? (NUM_VC'(1) << gnt_vc) : '0;
    end

    assign src_ready = gnt_oh;

    always_comb begin
        write_data_d = write_data_q;
        in_vc_d      = in_vc_q;
        rr_ptr_d     = rr_ptr_q;
        if (any_elig) begin
            write_data_d = src_data[int'(gnt_vc)*DATA_WIDTH +: DATA_WIDTH];
            in_vc_d      = gnt_vc;
            rr_ptr_d     = gnt_vc + BUF_BITS'(1);
        end
    end

    // One extra bit of headroom lets a return to a full counter be detected and clamped.
    always_comb begin
        logic [CW1-1:0] sum;
        logic           ret;
        err_d = err_q;
        sum   = '0;
        ret   = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            ret = credit_in && (credit_vc == BUF_BITS'(v));
            sum = {1'b0, credit_q[v]} - CW1'(gnt_oh[v]) + CW1'(ret);
            if (sum > CW1'(CMAX)) begin
                credit_d[v] = CW'(CMAX);
                err_d       = 1'b1;
            end else begin
                credit_d[v] = sum[CW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_elig)  state_d = SEND;
            SEND:    if (!any_elig) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wrtEn     = (state_q == SEND);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            write_data_q <= '0;
            in_vc_q      <= '0;
            err_q        <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CW'(CMAX);
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            write_data_q <= write_data_d;
            in_vc_q      <= in_vc_d;
            err_q        <= err_d;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
        end
    end

    always_comb begin
        credits = '0;
        for (int v = 0; v < NUM_VC; v++) credits[v*CW +: CW] = credit_q[v];
    end

    assign write_data = write_data_q;
    assign in_vc      = in_vc_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_vc_credit_tx_port.sv
// Bench for vc_credit_tx_port: directed scenarios plus random traffic, all checked against
// a cycle-level reference model built from integer credit counts and a flit queue.
module tb_vc_credit_tx_port;
  localparam int DW   = 32;
  localparam int BB   = 1;
  localparam int NV   = 2;
  localparam int QB   = 3;
  localparam int CW   = QB + 1;
  localparam int CMAX = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NV-1:0]      src_valid = '0;
  logic [NV*DW-1:0]   src_data = '0;
  logic [NV-1:0]      src_ready;
  logic               credit_in = 1'b0;
  logic [BB-1:0]      credit_vc = '0;
  logic               wrtEn;
  logic [DW-1:0]      write_data;
  logic [BB-1:0]      in_vc;
  logic [NV*CW-1:0]   credits;
  logic               credit_err;
  logic               dbg_state;

  vc_credit_tx_port #(.DATA_WIDTH(DW), .BUF_BITS(BB), .Q_DEPTH_BITS(QB)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .credit_in(credit_in), .credit_vc(credit_vc),
    .wrtEn(wrtEn), .write_data(write_data), .in_vc(in_vc), .credits(credits),
    .credit_err(credit_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // reference model state
  int                m_cred [NV];
  int                m_rr;
  bit                m_wen;
  bit                m_err;
  logic [DW+BB-1:0]  m_last;
  logic [DW+BB-1:0]  exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_cred[v] = CMAX;
    m_rr = 0;
    m_wen = 1'b0;
    m_err = 1'b0;
    m_last = '0;
    exp_q.delete();
  endtask

  function automatic logic [NV*CW-1:0] exp_credits();
    logic [NV*CW-1:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v*CW +: CW] = CW'(m_cred[v]);
    return r;
  endfunction

  task automatic check_outputs();
    logic [DW+BB-1:0] f;
    check("wrtEn", {63'd0, wrtEn}, {63'd0, m_wen});
    check("dbg_state", {63'd0, dbg_state}, {63'd0, m_wen});
    if (m_wen) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 64'd1, 64'd0);
      end else begin
        f = exp_q.pop_front();
        m_last = f;
        check("in_vc", 64'(in_vc), 64'(f[DW+BB-1:DW]));
        check("write_data", 64'(write_data), 64'(f[DW-1:0]));
      end
    end else begin
      check("hold_vc", 64'(in_vc), 64'(m_last[DW+BB-1:DW]));
      check("hold_data", 64'(write_data), 64'(m_last[DW-1:0]));
    end
    check("credits", 64'(credits), 64'(exp_credits()));
    check("credit_err", {63'd0, credit_err}, {63'd0, m_err});
  endtask

  // One cycle: drive inputs just after an edge, check the grant strobe, clock, check outputs.
  task automatic step(input logic [NV-1:0] v, input logic ci, input logic [BB-1:0] cvc);
    int g;
    int c;
    logic [NV-1:0] exp_rdy;
    src_valid = v;
    credit_in = ci;
    credit_vc = cvc;
    for (int i = 0; i < NV; i++) src_data[i*DW +: DW] = $urandom;
    #1;
    g = -1;
    for (int i = 0; i < NV; i++) begin
      c = (m_rr + i) % NV;
      if (g < 0 && v[c] && m_cred[c] > 0) g = c;
    end
    exp_rdy = (g < 0) ? '0 : NV'(1 << g);
    check("src_ready", 64'(src_ready), 64'(exp_rdy));
    @(posedge clk);
    if (g >= 0) begin
      exp_q.push_back({BB'(g), src_data[g*DW +: DW]});
      m_cred[g] = m_cred[g] - 1;
      m_rr = (g + 1) % NV;
      m_wen = 1'b1;
    end else begin
      m_wen = 1'b0;
    end
    if (ci) begin
      if (m_cred[cvc] >= CMAX) m_err = 1'b1;
      else m_cred[cvc] = m_cred[cvc] + 1;
    end
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    src_valid = '0;
    credit_in = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    #1;
    reset = 1'b1;
    #1;
    check("rst_wrtEn", {63'd0, wrtEn}, 64'd0);
    check("rst_err", {63'd0, credit_err}, 64'd0);
    check("rst_credits", 64'(credits), 64'h88);
  endtask

  initial begin
    // reset values
    do_reset();
    check_outputs();

    // single-VC burst exhausts VC0 credits after 8 flits
    for (int i = 0; i < 10; i++) step(2'b01, 1'b0, 1'b0);
    check("t2_cred0", 64'(credits[3:0]), 64'd0);
    check("t2_wrtEn", {63'd0, wrtEn}, 64'd0);
    for (int i = 0; i < 8; i++) step(2'b00, 1'b1, 1'b0);

    // round-robin alternation
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(2'b11, 1'b0, 1'b0);
      check("t3_vc", 64'(in_vc), 64'(i % 2));
    end

    // simultaneous send and return on VC1
    do_reset();
    for (int i = 0; i < 5; i++) step(2'b10, 1'b0, 1'b0);
    check("t4_pre", 64'(credits[7:4]), 64'd3);
    step(2'b10, 1'b1, 1'b1);
    check("t4_cred1", 64'(credits[7:4]), 64'd3);

    // zero-credit restart: returned credit usable only the cycle after
    do_reset();
    for (int i = 0; i < 8; i++) step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    check("t5_no_send", {63'd0, wrtEn}, 64'd0);
    step(2'b01, 1'b0, 1'b0);
    check("t5_wrtEn", {63'd0, wrtEn}, 64'd1);
    check("t5_vc", 64'(in_vc), 64'd0);

    // overflow is sticky until reset
    do_reset();
    step(2'b00, 1'b1, 1'b0);
    check("t6_cred0", 64'(credits[3:0]), 64'd8);
    check("t6_err", {63'd0, credit_err}, 64'd1);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0);
    check("t6_err_sticky", {63'd0, credit_err}, 64'd1);

    // asynchronous reset mid-burst
    #2;
    reset = 1'b0;
    #1;
    check("async_wrtEn", {63'd0, wrtEn}, 64'd0);
    check("async_credits", 64'(credits), 64'h88);
    check("async_err", {63'd0, credit_err}, 64'd0);
    do_reset();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(NV'($urandom_range(3, 0)), ($urandom_range(1, 0) == 0), BB'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
